// File: rtl/ysyx_25050148_lsu.sv
// Load/store unit: one outstanding data-memory transaction over a valid/ready request/response bus.
// Optional macro YSYX_25050148_LSU_MISALIGN_TRAP_EN faults misaligned half/word accesses without a bus request.
module ysyx_25050148_lsu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic              op_store,
    input  logic [1:0]        op_len,
    input  logic              op_unsigned,
    input  logic [ADDR_W-1:0] op_addr,
    input  logic [DATA_W-1:0] op_wdata,
    output logic              op_done,
    output logic [DATA_W-1:0] op_rdata,
    output logic              op_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [3:0]        mem_req_wstrb,
    input  logic              mem_resp_valid,
    output logic              mem_resp_ready,
    input  logic [DATA_W-1:0] mem_resp_rdata,
    input  logic              mem_resp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              store_q, store_d;
    logic [1:0]        len_q, len_d;
    logic              unsigned_q, unsigned_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [1:0]        lane_off;
    logic [4:0]        shift_amt;
    logic [DATA_W-1:0] rdata_shifted;
    logic [DATA_W-1:0] load_ext;
    logic [3:0]        strb_raw;

    assign lane_off  = addr_q[1:0];
    assign shift_amt = {lane_off, 3'b000};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            store_q    <= 1'b0;
            len_q      <= 2'd0;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            store_q    <= store_d;
            len_q      <= len_d;
            unsigned_q <= unsigned_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    // Logical shift zero-fills, so a half read at offset 3 sees only the top byte.
    always_comb begin
        rdata_shifted = mem_resp_rdata >> shift_amt;
        case (len_q)
            2'd0:    load_ext = {{24{~unsigned_q & rdata_shifted[7]}}, rdata_shifted[7:0]};
            2'd1:    load_ext = {{16{~unsigned_q & rdata_shifted[15]}}, rdata_shifted[15:0]};
            default: load_ext = rdata_shifted;
        endcase
    end

`ifdef YSYX_25050148_LSU_MISALIGN_TRAP_EN
    logic op_misaligned;
    assign op_misaligned = ((op_len == 2'd1) && op_addr[0]) ||
                           (op_len[1] && (op_addr[1:0] != 2'b00));
`endif

    always_comb begin
        state_d    = state_q;
        store_d    = store_q;
        len_d      = len_q;
        unsigned_d = unsigned_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        case (state_q)
            IDLE: begin
                if (op_valid) begin
                    store_d    = op_store;
                    len_d      = op_len;
                    unsigned_d = op_unsigned;
                    addr_d     = op_addr;
                    wdata_d    = op_wdata;
                    err_d      = 1'b0;
                    state_d    = REQ;
`ifdef YSYX_25050148_LSU_MISALIGN_TRAP_EN
                    if (op_misaligned) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
`endif
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (mem_resp_valid) begin
                    err_d = mem_resp_err;
                    if (!store_q && !mem_resp_err) begin
                        rdata_d = load_ext;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobe shift is evaluated at 4 bits so a half at offset 3 truncates to 4'b1000.
    always_comb begin
        case (len_q)
            2'd0:    strb_raw = 4'b0001 << lane_off;
            2'd1:    strb_raw = 4'b0011 << lane_off;
            default: strb_raw = 4'b1111;
        endcase
        case (len_q)
            2'd0:    mem_req_wdata = {4{wdata_q[7:0]}};
            2'd1:    mem_req_wdata = {2{wdata_q[15:0]}};
            default: mem_req_wdata = wdata_q;
        endcase
    end

    assign mem_req_wstrb  = store_q ? strb_raw : 4'b0000;
    assign mem_req_we     = store_q;
    assign mem_req_addr   = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_req_valid  = (state_q == REQ);
    assign mem_resp_ready = (state_q == RESP);
    assign op_ready       = (state_q == IDLE);
    assign op_done        = (state_q == DONE);
    assign op_err         = (state_q == DONE) && err_q;
    assign op_rdata       = rdata_q;

endmodule

// File: tb/tb_ysyx_25050148_lsu.sv
// Randomized bench for ysyx_25050148_lsu against a byte-lane reference model.
// Honours YSYX_25050148_LSU_MISALIGN_TRAP_EN when compiled with it.
module tb_ysyx_25050148_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid, op_ready, op_store, op_unsigned;
    logic [1:0]  op_len;
    logic [31:0] op_addr, op_wdata, op_rdata;
    logic        op_done, op_err;
    logic        mem_req_valid, mem_req_ready, mem_req_we;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_resp_valid, mem_resp_ready, mem_resp_err;
    logic [31:0] mem_resp_rdata;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_rdata;

    always #5 clk = ~clk;

    ysyx_25050148_lsu dut (
        .clk(clk), .rst_n(rst_n),
        .op_valid(op_valid), .op_ready(op_ready), .op_store(op_store),
        .op_len(op_len), .op_unsigned(op_unsigned), .op_addr(op_addr),
        .op_wdata(op_wdata), .op_done(op_done), .op_rdata(op_rdata), .op_err(op_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
        .mem_resp_rdata(mem_resp_rdata), .mem_resp_err(mem_resp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Extract the addressed bytes and extend them, using plain integer arithmetic.
    function automatic logic [31:0] load_model(input logic [31:0] rd, input logic [1:0] len,
                                               input bit uns, input logic [1:0] o);
        longint v;
        int     bits;
        bits = (len == 2'd0) ? 8 : (len == 2'd1) ? 16 : 32;
        v = longint'({32'b0, rd}) >> (8 * int'(o));
        v = v % (64'sd1 << bits);
        if (!uns && bits < 32 && v >= (64'sd1 << (bits - 1))) v = v - (64'sd1 << bits);
        return v[31:0];
    endfunction

    task automatic do_op(input bit st, input logic [1:0] len, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input bit er, input int rq_w, input int rs_w);
        logic [31:0] e_wd;
        logic [3:0]  e_st;
        int          o, nbytes;
        bit          mis;
        o = int'(addr[1:0]);
        mis = 1'b0;
`ifdef YSYX_25050148_LSU_MISALIGN_TRAP_EN
        mis = (len == 2'd1 && addr[0]) || (len >= 2'd2 && o != 0);
`endif
        nbytes = (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
        e_st = 4'b0000;
        if (st) begin
            if (nbytes == 4) e_st = 4'b1111;
            else for (int b = o; b < o + nbytes && b < 4; b++) e_st[b] = 1'b1;
        end
        e_wd = (nbytes == 1) ? {4{wd[7:0]}} : (nbytes == 2) ? {2{wd[15:0]}} : wd;

        chk("op_ready_idle", {31'b0, op_ready}, 32'd1);
        op_valid = 1'b1; op_store = st; op_len = len; op_unsigned = uns;
        op_addr = addr; op_wdata = wd;
        @(posedge clk); #1;
        op_valid = 1'b0; op_store = 1'($urandom); op_len = 2'($urandom);
        op_unsigned = 1'($urandom); op_addr = $urandom; op_wdata = $urandom;

        if (mis) begin
            chk("trap_done", {31'b0, op_done}, 32'd1);
            chk("trap_err", {31'b0, op_err}, 32'd1);
            chk("trap_noreq", {31'b0, mem_req_valid}, 32'd0);
            chk("trap_rdata", op_rdata, exp_rdata);
            @(posedge clk); #1;
            chk("trap_ready_after", {31'b0, op_ready}, 32'd1);
            chk("trap_done_pulse", {31'b0, op_done}, 32'd0);
            $display("op trap st=%0d len=%0d addr=%h", st, len, addr);
            return;
        end

        for (int i = 0; i <= rq_w; i++) begin
            chk("req_valid", {31'b0, mem_req_valid}, 32'd1);
            chk("req_addr", mem_req_addr, {addr[31:2], 2'b00});
            chk("req_we", {31'b0, mem_req_we}, {31'b0, st});
            chk("req_wstrb", {28'b0, mem_req_wstrb}, {28'b0, e_st});
            if (st) chk("req_wdata", mem_req_wdata, e_wd);
            chk("op_ready_busy", {31'b0, op_ready}, 32'd0);
            mem_req_ready = (i == rq_w);
            @(posedge clk); #1;
        end
        mem_req_ready = 1'b0;

        for (int i = 0; i <= rs_w; i++) begin
            chk("resp_ready", {31'b0, mem_resp_ready}, 32'd1);
            chk("req_dropped", {31'b0, mem_req_valid}, 32'd0);
            chk("no_early_done", {31'b0, op_done}, 32'd0);
            if (i == rs_w) begin
                mem_resp_valid = 1'b1; mem_resp_rdata = rd; mem_resp_err = er;
            end else begin
                mem_resp_valid = 1'b0; mem_resp_rdata = $urandom; mem_resp_err = 1'($urandom);
            end
            @(posedge clk); #1;
        end
        mem_resp_valid = 1'b0;

        if (!st && !er) exp_rdata = load_model(rd, len, uns, addr[1:0]);
        chk("done", {31'b0, op_done}, 32'd1);
        chk("err", {31'b0, op_err}, {31'b0, er});
        chk("rdata", op_rdata, exp_rdata);
        chk("op_ready_done", {31'b0, op_ready}, 32'd0);
        @(posedge clk); #1;
        chk("done_pulse", {31'b0, op_done}, 32'd0);
        chk("ready_after", {31'b0, op_ready}, 32'd1);
        $display("op st=%0d len=%0d uns=%0d addr=%h wd=%h rd=%h err=%0d -> rdata=%h",
                 st, len, uns, addr, wd, rd, er, op_rdata);
    endtask

    initial begin
        rst_n = 1'b0;
        op_valid = 1'b0; op_store = 1'b0; op_len = 2'd0; op_unsigned = 1'b0;
        op_addr = '0; op_wdata = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0; mem_resp_err = 1'b0;
        exp_rdata = '0;
        #12;
        chk("rst_op_ready", {31'b0, op_ready}, 32'd1);
        chk("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
        chk("rst_wstrb", {28'b0, mem_req_wstrb}, 32'd0);
        chk("rst_rdata", op_rdata, 32'd0);
        chk("rst_done", {31'b0, op_done}, 32'd0);
        #5 rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(1'b0, 2'd0, 1'b0, 32'h80000002, 32'h0, 32'h12F45678, 1'b0, 0, 0);
        chk("tp_lb_signed", op_rdata, 32'hFFFFFFF4);
        do_op(1'b1, 2'd1, 1'b0, 32'h80000006, 32'h0000BEEF, 32'h0, 1'b0, 0, 0);
        chk("tp_sh_keeps_rdata", op_rdata, 32'hFFFFFFF4);
        do_op(1'b0, 2'd1, 1'b1, 32'h00000010, 32'h0, 32'h8001ABCD, 1'b0, 3, 2);
        chk("tp_lhu", op_rdata, 32'h0000ABCD);
        do_op(1'b0, 2'd2, 1'b0, 32'h00000020, 32'h0, 32'hDEADBEEF, 1'b1, 0, 0);
        chk("tp_lw_err_keeps", op_rdata, 32'h0000ABCD);
        do_op(1'b0, 2'd2, 1'b0, 32'h00000003, 32'h0, 32'hA1B2C3D4, 1'b0, 0, 0);
        do_op(1'b1, 2'd1, 1'b0, 32'h00000103, 32'h00001234, 32'h0, 1'b0, 1, 0);

        // Reset asserted while the LSU waits for a response.
        op_valid = 1'b1; op_store = 1'b1; op_len = 2'd2; op_addr = 32'h100; op_wdata = 32'h55;
        @(posedge clk); #1;
        op_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        chk("pre_rst_resp_ready", {31'b0, mem_resp_ready}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        exp_rdata = '0;
        chk("arst_op_ready", {31'b0, op_ready}, 32'd1);
        chk("arst_resp_ready", {31'b0, mem_resp_ready}, 32'd0);
        chk("arst_we", {31'b0, mem_req_we}, 32'd0);
        chk("arst_wstrb", {28'b0, mem_req_wstrb}, 32'd0);
        chk("arst_rdata", op_rdata, 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(1'b0, 2'd2, 1'b0, 32'h00000040, 32'h0, 32'hCAFEF00D, 1'b0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            do_op(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
                  ($urandom_range(0, 7) == 0), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ysyx_25050148_lsu.md
Name: ysyx_25050148_lsu

Overview:
Load/store unit that initiates data-memory transactions for the core over a valid/ready request and response bus. It is the initiator counterpart of the data-memory responder.
- Accepts one load or store from execute.
- Aligns store data and builds byte strobes.
- Issues the request and waits for the response.
- Sign- or zero-extends load data and signals completion to writeback.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, bus data width; fixed at 32, other values unsupported

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- op_valid  in  1  execute presents an operation
- op_ready  out  1  LSU can accept an operation
- op_store  in  1  1 = store, 0 = load
- op_len  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word
- op_unsigned  in  1  load zero-extends when 1
- op_addr  in  32  byte address
- op_wdata  in  32  store data, right-aligned
- op_done  out  1  one-cycle completion pulse
- op_rdata  out  32  extended load result
- op_err  out  1  qualifies op_done; operation faulted
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  responder accepts request
- mem_req_we  out  1  write request
- mem_req_addr  out  32  word-aligned address, {addr[31:2],2'b00}
- mem_req_wdata  out  32  lane-shifted store data
- mem_req_wstrb  out  4  byte strobes; 0 for reads
- mem_resp_valid  in  1  response valid
- mem_resp_ready  out  1  LSU accepts response
- mem_resp_rdata  in  32  full read word
- mem_resp_err  in  1  access fault

Behaviour:
Clocking and reset:
- One clock; reset is asynchronous and active-low.
- On reset assertion, including mid-transaction:
  - state = IDLE
  - op_ready = 1
  - op_done, op_err, mem_req_valid, mem_resp_ready, mem_req_we = 0
  - mem_req_wstrb = 0, op_rdata = 0
  - any in-flight bus transaction is abandoned.

FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - op_ready = 1.
  - op_valid latches op_store, op_len, op_unsigned, op_addr and op_wdata into internal registers, then moves to REQ.
- REQ:
  - mem_req_valid = 1; address, data and strobes are stable while valid is high.
  - mem_req_ready = 1 moves to RESP; otherwise the state holds indefinitely.
- RESP:
  - mem_resp_ready = 1.
  - mem_resp_valid = 1 captures data and error, then moves to DONE.
- DONE:
  - op_done = 1 for exactly one cycle, then return to IDLE.
  - op_ready = 0 in REQ, RESP and DONE.

Timing:
- Accept at cycle T; mem_req_valid is high from T+1.
- With zero-wait handshakes, the response is captured at T+2 and op_done is asserted at T+3.
- Minimum 4 cycles per operation; no pipelining; one outstanding transaction.

Store lanes, with o = addr[1:0]:
- byte: wdata = {4{d[7:0]}}, wstrb = 4'b0001 << o
- half: wdata = {2{d[15:0]}}, wstrb = 4'b0011 << o
- word: wdata = d, wstrb = 4'b1111

Load extraction:
- Shift mem_resp_rdata right by 8*o, then truncate to the operand size.
- Sign-extend when op_unsigned = 0; zero-extend when op_unsigned = 1.
- op_rdata updates only on load completion without error and holds otherwise.
- Stores leave op_rdata unchanged.

Errors:
- op_err = mem_resp_err captured in RESP, valid only while op_done is high.
- A load that completes with an error leaves op_rdata unchanged.

Misaligned accesses (without the optional feature):
- A half access with o = 3 wraps within the word: the strobe shift truncates to 4'b1000, and the read takes the upper byte zero-filled before extension.
- No straddling transfer is ever issued.

Optional Feature:
- Macro: YSYX_25050148_LSU_MISALIGN_TRAP_EN
- Defined:
  - Misaligned operations are half with addr[0] = 1, or word with addr[1:0] != 0.
  - These go from IDLE directly to DONE with op_err = 1.
  - No bus request is issued and op_rdata is unchanged; latency is 2 cycles.
- Undefined: the wrap behaviour above applies, and op_err reflects mem_resp_err only.

Test Plan:
- Load byte signed, addr 0x80000002, resp rdata 0x12F45678, zero-wait: req addr 0x80000000 at T+1; op_done at T+3 with op_rdata 0xFFFFFFF4 (byte 0xF4 sign-extended).
- Store half, addr 0x80000006, wdata 0x0000BEEF: mem_req_we = 1, wstrb 4'b1100, mem_req_wdata 0xBEEFBEEF, req addr 0x80000004; op_rdata unchanged.
- Load half unsigned, addr 0x10, rdata 0x8001ABCD; mem_req_ready held low for 3 cycles, then response delayed 2 cycles: req fields stable throughout; op_done 1 cycle with op_rdata 0x0000ABCD; op_ready low until the cycle after op_done.
- Load word with mem_resp_err = 1: op_done with op_err = 1, op_rdata keeps its prior value 0x0000ABCD.
- Misaligned word, addr 0x3:
  - Macro defined: no mem_req_valid, op_done at T+1 with op_err = 1.
  - Macro undefined: request to addr 0x0, wstrb 0 for the load.
- rst_n pulsed low while in RESP: all outputs return to reset values asynchronously; a subsequent load completes normally.
